ibex_multdiv_iter: RTL

- Parametrised iterative radix-2 multiply/divide unit, successor to the slow multdiv.
- Has its own internal (WIDTH+1)-bit adder, so it does not share the ALU adder.
- Uses valid/ready handshakes on both the request and result sides, and supports abort.
- Operand width is configurable, and a fast path handles trivial operands. Sits beside the ALU in the execute stage.

---
 rtl/ibex_multdiv_iter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ibex_multdiv_iter.sv
// Iterative radix-2 multiply/divide unit with valid/ready handshakes and abort.
// It has its own (WIDTH+1)-bit adder and a fast path for zero operands.
module ibex_multdiv_iter #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          ZERO_SKIP = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             abort_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             div_by_zero_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]  op_a_q, op_b_q;
    logic [1:0]        operator_q, mode_q;
    logic [WIDTH-1:0]  a_mag_q, b_mag_q;
    logic              sa_q, neg_q, bz_q;
    logic [PROD_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  result_q;
    logic              dbz_q;

    logic              load_res;
    logic [WIDTH-1:0]  res_d;
    logic              dbz_d;

    // Operand classification, evaluated from the captured request during PREP.
    logic              sa_c, sb_c, is_mul_c, a_zero_c, b_zero_c, fast_c;
    logic [WIDTH-1:0]  a_mag_c, b_mag_c, fast_res_c;

    always_comb begin
        sa_c     = mode_q[0] & op_a_q[WIDTH-1];
        sb_c     = mode_q[1] & op_b_q[WIDTH-1];
        a_mag_c  = sa_c ? (~op_a_q + WIDTH'(1)) : op_a_q;
        b_mag_c  = sb_c ? (~op_b_q + WIDTH'(1)) : op_b_q;
        is_mul_c = (operator_q == OP_MUL) || (operator_q == OP_MULH);
        a_zero_c = (op_a_q == '0);
        b_zero_c = (op_b_q == '0);
        fast_c   = ZERO_SKIP && ((is_mul_c && (a_zero_c || b_zero_c)) ||
                                 (!is_mul_c && b_zero_c));
        case (operator_q)
            OP_DIV:  fast_res_c = '1;
            OP_REM:  fast_res_c = op_a_q;
            default: fast_res_c = '0;
        endcase
    end

    // Shared (WIDTH+1)-bit adder: accumulate for multiply, trial subtract for divide.
    logic [WIDTH:0]    add_a, add_b;
    logic              add_cin;
    logic [WIDTH+1:0]  add_sum;
    logic              no_borrow;
    logic [WIDTH-1:0]  rem_next;
    logic [PROD_W-1:0] acc_iter;

    always_comb begin
        if (operator_q[1]) begin
            add_a   = acc_q[PROD_W-1:WIDTH-1];
            add_b   = ~{1'b0, b_mag_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc_q[PROD_W-1:WIDTH]};
            add_b   = acc_q[0] ? {1'b0, a_mag_q} : '0;
            add_cin = 1'b0;
        end
        add_sum   = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
        no_borrow = add_sum[WIDTH+1];
        rem_next  = no_borrow ? add_sum[WIDTH-1:0] : acc_q[PROD_W-2:WIDTH-1];
        if (operator_q[1]) begin
            acc_iter = {rem_next, acc_q[WIDTH-2:0], no_borrow};
        end else begin
            acc_iter = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the magnitude result.
    logic [PROD_W-1:0] prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix, fix_res_c;

    always_comb begin
        prod_fix = neg_q ? (~acc_q + PROD_W'(1)) : acc_q;
        // A zero divisor keeps the all-ones quotient whatever the dividend sign.
        quo_fix  = (neg_q && !bz_q) ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem_fix  = sa_q ? (~acc_q[PROD_W-1:WIDTH] + WIDTH'(1)) : acc_q[PROD_W-1:WIDTH];
        case (operator_q)
            OP_MUL:  fix_res_c = prod_fix[WIDTH-1:0];
            OP_MULH: fix_res_c = prod_fix[PROD_W-1:WIDTH];
            OP_DIV:  fix_res_c = quo_fix;
            default: fix_res_c = rem_fix;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and result-load decision.
    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
        res_d    = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: if (in_valid_i) state_d = S_PREP;
            S_PREP: begin
                if (fast_c) begin
                    state_d  = S_DONE;
                    load_res = 1'b1;
                    res_d    = fast_res_c;
                    dbz_d    = !is_mul_c && b_zero_c;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX: begin
                state_d  = S_DONE;
                load_res = 1'b1;
                res_d    = fix_res_c;
                dbz_d    = bz_q;
            end
            S_DONE: if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort beats completion and the result handshake.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            load_res = 1'b0;
        end
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
            end
            S_DONE:  out_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign result_o      = result_q;
    assign div_by_zero_o = dbz_q;

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            operator_q <= '0;
            mode_q     <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            sa_q       <= 1'b0;
            neg_q      <= 1'b0;
            bz_q       <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && in_valid_i) begin
                op_a_q     <= op_a_i;
                op_b_q     <= op_b_i;
                operator_q <= operator_i;
                mode_q     <= signed_mode_i;
            end
            if (state_q == S_PREP) begin
                a_mag_q <= a_mag_c;
                b_mag_q <= b_mag_c;
                sa_q    <= sa_c;
                neg_q   <= sa_c ^ sb_c;
                bz_q    <= !is_mul_c && b_zero_c;
                acc_q   <= {{WIDTH{1'b0}}, (is_mul_c ? b_mag_c : a_mag_c)};
                cnt_q   <= CNT_W'(WIDTH);
            end
            if (state_q == S_CALC) begin
                acc_q <= acc_iter;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (load_res) begin
                result_q <= res_d;
                dbz_q    <= dbz_d;
            end
        end
    end

endmodule
